// File: rtl/instr_fetch_if.sv
// Instruction-fetch port bundle: redirect/hazard controls from decode, the
// synchronous instruction ROM port, the IF/ID register outputs and debug taps.
//
// Handshake: there is no ready signal. valid_out qualifies instr_out, pc_out
// and pc_plus1_out on every cycle; stall is the only backpressure and, when
// high at an edge without redirect or flush, freezes the IF/ID register.
interface instr_fetch_if;
  // Control from decode / hazard logic
  logic        stall;
  logic        flush;
  logic        pc_redirect;
  logic [15:0] redirect_addr;

  // Synchronous instruction ROM
  logic [15:0] imem_addr;
  logic        imem_rd_en;
  logic [31:0] imem_data;

  // IF/ID register
  logic [31:0] instr_out;
  logic [15:0] pc_out;
  logic [15:0] pc_plus1_out;
  logic        valid_out;
  logic [15:0] fetch_count;

  // Debug taps: FSM state (0=BOOT, 1=RUN, 2=BUBBLE) and next fetch address
  logic [1:0]  state_dbg;
  logic [15:0] pc_dbg;

  // Fetch unit side
  modport master (
    input  stall, flush, pc_redirect, redirect_addr, imem_data,
    output imem_addr, imem_rd_en, instr_out, pc_out, pc_plus1_out,
           valid_out, fetch_count, state_dbg, pc_dbg
  );

  // Decode stage / ROM / bench side
  modport slave (
    output stall, flush, pc_redirect, redirect_addr, imem_data,
    input  imem_addr, imem_rd_en, instr_out, pc_out, pc_plus1_out,
           valid_out, fetch_count, state_dbg, pc_dbg
  );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch stage with a one-cycle synchronous ROM.
// pc_q is the next address to present to the ROM; f1_pc_q is the address the
// ROM latched on the previous edge, i.e. the address of the word currently on
// imem_data. The FSM decides whether imem_data is trusted (RUN) or must be
// replaced by a bubble (BOOT after reset, BUBBLE after a redirect, where the
// ROM still returns the old sequential word).
module instr_fetch #(
  parameter logic [15:0] RESET_VEC = 16'h0000,
  parameter logic [31:0] NOP_INSTR = 32'hFFFFFFFF
) (
  input  logic         clk,
  input  logic         rst,
  instr_fetch_if.master bus
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    BUBBLE = 2'd2
  } state_t;

  state_t      state_q;
  logic [15:0] pc_q;
  logic [15:0] f1_pc_q;
  logic [31:0] instr_q;
  logic [15:0] pc_out_q;
  logic        valid_q;
  logic [15:0] fetch_count_q;

  logic [15:0] pc_inc;
  assign pc_inc = pc_q + 16'd1;

  // ROM address: while stalled (and not redirecting) re-read the in-flight
  // address so the same word is waiting on imem_data when the stall releases.
  always_comb begin
    bus.imem_addr = pc_q;
    if (bus.stall && !bus.pc_redirect) begin
      bus.imem_addr = f1_pc_q;
    end
  end

  // The ROM is idle only while reset is held.
  assign bus.imem_rd_en = rst;

  // Fetch pipeline and FSM; priority reset > redirect > flush > stall > advance.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q          <= RESET_VEC;
      f1_pc_q       <= RESET_VEC;
      state_q       <= BOOT;
      instr_q       <= NOP_INSTR;
      pc_out_q      <= RESET_VEC;
      valid_q       <= 1'b0;
      fetch_count_q <= 16'd0;
    end else if (bus.pc_redirect) begin
      // The ROM latches the old sequential pc_q this edge; that word comes
      // back next cycle and is dropped in BUBBLE.
      pc_q    <= bus.redirect_addr;
      f1_pc_q <= pc_q;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      state_q <= BUBBLE;
    end else if (bus.flush) begin
      // Only the IF/ID register is cleared; fetching keeps moving, so the
      // word in flight this cycle is lost.
      pc_q    <= pc_inc;
      f1_pc_q <= pc_q;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      state_q <= RUN;
    end else if (bus.stall) begin
      // Hold everything; the ROM re-reads f1_pc_q.
      pc_q    <= pc_q;
      f1_pc_q <= f1_pc_q;
      state_q <= state_q;
    end else begin
      pc_q    <= pc_inc;
      f1_pc_q <= pc_q;
      state_q <= RUN;
      if (state_q == RUN) begin
        instr_q       <= bus.imem_data;
        pc_out_q      <= f1_pc_q;
        valid_q       <= 1'b1;
        fetch_count_q <= fetch_count_q + 16'd1;
      end else begin
        instr_q <= NOP_INSTR;
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.instr_out    = instr_q;
  assign bus.pc_out       = pc_out_q;
  assign bus.pc_plus1_out = pc_out_q + 16'd1;
  assign bus.valid_out    = valid_q;
  assign bus.fetch_count  = fetch_count_q;
  assign bus.state_dbg    = state_q;
  assign bus.pc_dbg       = pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: boot, stall, redirect under stall, flush,
// back-to-back redirects, PC wrap and mid-bubble reset.
module tb_instr_fetch;

  // Clock and reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  instr_fetch_if bus();

  instr_fetch #(
    .RESET_VEC(16'h0000),
    .NOP_INSTR(32'hFFFFFFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  // ROM contents: two fixed boot words, otherwise {~addr, addr}.
  function automatic logic [31:0] rom_word(input logic [15:0] a);
    case (a)
      16'h0000: rom_word = 32'h80010002;
      16'h0001: rom_word = 32'h84030004;
      default:  rom_word = {~a, a};
    endcase
  endfunction

  // Synchronous ROM model
  always @(posedge clk) begin
    if (bus.imem_rd_en) bus.imem_data <= rom_word(bus.imem_addr);
  end

  // Advance one edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic s, input logic f, input logic r, input logic [15:0] a);
    bus.stall = s;
    bus.flush = f;
    bus.pc_redirect = r;
    bus.redirect_addr = a;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", bus.valid_out); end
    checks++; if (bus.instr_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL reset_instr: got %h expected ffffffff", bus.instr_out); end
    checks++; if (bus.pc_out !== 16'h0000) begin errors++; $display("FAIL reset_pc_out: got %h expected 0000", bus.pc_out); end
    checks++; if (bus.fetch_count !== 16'h0000) begin errors++; $display("FAIL reset_count: got %h expected 0000", bus.fetch_count); end
    checks++; if (bus.state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state_dbg); end
    checks++; if (bus.imem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", bus.imem_rd_en); end
  endtask

  task automatic test_boot();
    rst = 1'b1;
    #1;
    checks++; if (bus.imem_rd_en !== 1'b1) begin errors++; $display("FAIL boot_rd_en: got %b expected 1", bus.imem_rd_en); end
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL boot_e1_valid: got %b expected 0", bus.valid_out); end
    checks++; if (bus.state_dbg !== 2'd1) begin errors++; $display("FAIL boot_e1_state: got %0d expected 1", bus.state_dbg); end
    tick();
    checks++; if (bus.instr_out !== 32'h80010002) begin errors++; $display("FAIL boot_e2_instr: got %h expected 80010002", bus.instr_out); end
    checks++; if (bus.pc_out !== 16'h0000 || bus.valid_out !== 1'b1) begin errors++; $display("FAIL boot_e2_pc: got %h/%b expected 0000/1", bus.pc_out, bus.valid_out); end
    tick();
    checks++; if (bus.instr_out !== 32'h84030004) begin errors++; $display("FAIL boot_e3_instr: got %h expected 84030004", bus.instr_out); end
    checks++; if (bus.pc_out !== 16'h0001) begin errors++; $display("FAIL boot_e3_pc: got %h expected 0001", bus.pc_out); end
    checks++; if (bus.fetch_count !== 16'd2) begin errors++; $display("FAIL boot_e3_count: got %0d expected 2", bus.fetch_count); end
    checks++; if (bus.pc_plus1_out !== 16'h0002) begin errors++; $display("FAIL boot_e3_plus1: got %h expected 0002", bus.pc_plus1_out); end
    repeat (4) tick();
    checks++; if (bus.pc_out !== 16'h0005 || bus.instr_out !== 32'hFFFA0005) begin errors++; $display("FAIL run_pc5: got %h/%h expected 0005/fffa0005", bus.pc_out, bus.instr_out); end
  endtask

  task automatic test_stall();
    set_in(1'b1, 1'b0, 1'b0, 16'h0000);
    #1;
    checks++; if (bus.imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_addr_pre: got %h expected 0006", bus.imem_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.pc_out !== 16'h0005 || bus.instr_out !== 32'hFFFA0005 || bus.valid_out !== 1'b1) begin errors++; $display("FAIL stall_hold%0d: got %h/%h/%b expected 0005/fffa0005/1", i, bus.pc_out, bus.instr_out, bus.valid_out); end
      checks++; if (bus.imem_addr !== 16'h0006) begin errors++; $display("FAIL stall_addr%0d: got %h expected 0006", i, bus.imem_addr); end
      checks++; if (bus.fetch_count !== 16'd6) begin errors++; $display("FAIL stall_count%0d: got %0d expected 6", i, bus.fetch_count); end
    end
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (bus.pc_out !== 16'h0006 || bus.instr_out !== 32'hFFF90006) begin errors++; $display("FAIL stall_release: got %h/%h expected 0006/fff90006", bus.pc_out, bus.instr_out); end
    checks++; if (bus.fetch_count !== 16'd7) begin errors++; $display("FAIL stall_release_count: got %0d expected 7", bus.fetch_count); end
    tick();
    checks++; if (bus.pc_out !== 16'h0007 || bus.instr_out !== 32'hFFF80007) begin errors++; $display("FAIL stall_next: got %h/%h expected 0007/fff80007", bus.pc_out, bus.instr_out); end
  endtask

  task automatic test_redirect();
    set_in(1'b1, 1'b0, 1'b1, 16'h0040);
    #1;
    checks++; if (bus.imem_addr !== 16'h0009) begin errors++; $display("FAIL redir_addr: got %h expected 0009", bus.imem_addr); end
    tick();
    checks++; if (bus.valid_out !== 1'b0 || bus.instr_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL redir_e1: got %b/%h expected 0/ffffffff", bus.valid_out, bus.instr_out); end
    checks++; if (bus.state_dbg !== 2'd2 || bus.pc_dbg !== 16'h0040) begin errors++; $display("FAIL redir_state: got %0d/%h expected 2/0040", bus.state_dbg, bus.pc_dbg); end
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL redir_e2_valid: got %b expected 0", bus.valid_out); end
    tick();
    checks++; if (bus.instr_out !== 32'hFFBF0040 || bus.pc_out !== 16'h0040) begin errors++; $display("FAIL redir_target: got %h/%h expected ffbf0040/0040", bus.instr_out, bus.pc_out); end
    checks++; if (bus.pc_plus1_out !== 16'h0041 || bus.fetch_count !== 16'd9) begin errors++; $display("FAIL redir_plus1: got %h/%0d expected 0041/9", bus.pc_plus1_out, bus.fetch_count); end
  endtask

  task automatic test_flush();
    set_in(1'b0, 1'b0, 1'b1, 16'h0010);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) tick();
    checks++; if (bus.pc_out !== 16'h0010 || bus.fetch_count !== 16'd10) begin errors++; $display("FAIL flush_setup: got %h/%0d expected 0010/10", bus.pc_out, bus.fetch_count); end
    bus.flush = 1'b1;
    tick();
    checks++; if (bus.valid_out !== 1'b0 || bus.instr_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL flush_edge: got %b/%h expected 0/ffffffff", bus.valid_out, bus.instr_out); end
    checks++; if (bus.fetch_count !== 16'd10) begin errors++; $display("FAIL flush_count: got %0d expected 10", bus.fetch_count); end
    bus.flush = 1'b0;
    tick();
    checks++; if (bus.pc_out !== 16'h0012 || bus.instr_out !== 32'hFFED0012) begin errors++; $display("FAIL flush_next: got %h/%h expected 0012/ffed0012", bus.pc_out, bus.instr_out); end
    checks++; if (bus.fetch_count !== 16'd11) begin errors++; $display("FAIL flush_next_count: got %0d expected 11", bus.fetch_count); end
  endtask

  task automatic test_back_to_back();
    set_in(1'b0, 1'b0, 1'b1, 16'h0020);
    tick();
    bus.redirect_addr = 16'h0030;
    tick();
    checks++; if (bus.state_dbg !== 2'd2 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_state: got %0d/%b expected 2/0", bus.state_dbg, bus.valid_out); end
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL b2b_bubble: got %b expected 0", bus.valid_out); end
    tick();
    checks++; if (bus.pc_out !== 16'h0030 || bus.instr_out !== 32'hFFCF0030) begin errors++; $display("FAIL b2b_target: got %h/%h expected 0030/ffcf0030", bus.pc_out, bus.instr_out); end
  endtask

  task automatic test_wrap();
    set_in(1'b0, 1'b0, 1'b1, 16'hFFFE);
    tick();
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (2) tick();
    checks++; if (bus.pc_out !== 16'hFFFE || bus.instr_out !== 32'h0001FFFE) begin errors++; $display("FAIL wrap_fffe: got %h/%h expected fffe/0001fffe", bus.pc_out, bus.instr_out); end
    tick();
    checks++; if (bus.pc_out !== 16'hFFFF || bus.pc_plus1_out !== 16'h0000) begin errors++; $display("FAIL wrap_ffff: got %h/%h expected ffff/0000", bus.pc_out, bus.pc_plus1_out); end
    tick();
    checks++; if (bus.pc_out !== 16'h0000 || bus.instr_out !== 32'h80010002) begin errors++; $display("FAIL wrap_0000: got %h/%h expected 0000/80010002", bus.pc_out, bus.instr_out); end
    checks++; if (bus.fetch_count !== 16'd15) begin errors++; $display("FAIL wrap_count: got %0d expected 15", bus.fetch_count); end
  endtask

  task automatic test_mid_reset();
    set_in(1'b0, 1'b0, 1'b1, 16'h0050);
    tick();
    rst = 1'b0;
    set_in(1'b1, 1'b1, 1'b1, 16'h0060);
    tick();
    checks++; if (bus.state_dbg !== 2'd0 || bus.pc_dbg !== 16'h0000) begin errors++; $display("FAIL mrst_state: got %0d/%h expected 0/0000", bus.state_dbg, bus.pc_dbg); end
    checks++; if (bus.fetch_count !== 16'd0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL mrst_count: got %0d/%b expected 0/0", bus.fetch_count, bus.valid_out); end
    checks++; if (bus.pc_out !== 16'h0000 || bus.instr_out !== 32'hFFFFFFFF) begin errors++; $display("FAIL mrst_out: got %h/%h expected 0000/ffffffff", bus.pc_out, bus.instr_out); end
    rst = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL mrst_e1: got %b expected 0", bus.valid_out); end
    tick();
    checks++; if (bus.instr_out !== 32'h80010002 || bus.fetch_count !== 16'd1) begin errors++; $display("FAIL mrst_e2: got %h/%0d expected 80010002/1", bus.instr_out, bus.fetch_count); end
  endtask

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 16'h0000);
    test_reset();
    test_boot();
    test_stall();
    test_redirect();
    test_flush();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
